matrix_transpose: RTL and testbench



---
 rtl/math_pkg.sv | 13 +
 rtl/transpose_core.sv | 15 +
 rtl/matrix_transpose.sv | 48 ++++
 tb/tb_matrix_transpose.sv | 137 +++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared constants and packing helper for the math modules
package math_pkg;

  localparam int MAT_N    = 4;
  localparam int MAT_W    = 16;
  localparam int MAT_BITS = MAT_N * MAT_N * MAT_W;

  // LSB position of element (r,c); row 0, col 0 sits in the least significant W bits
  function automatic int elem_lsb(input int r, input int c);
    return (r * MAT_N + c) * MAT_W;
  endfunction

endpackage

// File: rtl/transpose_core.sv
// rtl/transpose_core.sv - combinational flat-packed N x N transpose (pure rewiring)
module transpose_core
  import math_pkg::*;
(
  input  logic [MAT_BITS-1:0] m_in,
  output logic [MAT_BITS-1:0] m_t
);

  for (genvar r = 0; r < MAT_N; r++) begin : g_row
    for (genvar c = 0; c < MAT_N; c++) begin : g_col
      assign m_t[elem_lsb(r, c) +: MAT_W] = m_in[elem_lsb(c, r) +: MAT_W];
    end
  end

endmodule

// File: rtl/matrix_transpose.sv
// rtl/matrix_transpose.sv - registered 4x4 transpose with capture enable and done flag
module matrix_transpose
  import math_pkg::*;
#(
  parameter int N = MAT_N,
  parameter int W = MAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N*N*W-1:0] matrix,
  output logic [N*N*W-1:0] m_out,
  output logic             done
);

  logic [N*N*W-1:0] m_t;
  logic [N*N*W-1:0] m_out_d, m_out_q;
  logic             done_d, done_q;

  transpose_core u_core (
    .m_in (matrix),
    .m_t  (m_t)
  );

  // done only reflects the most recent edge, so it drops on any non-capturing cycle
  always_comb begin
    m_out_d = m_out_q;
    done_d  = 1'b0;
    if (enable) begin
      m_out_d = m_t;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      m_out_q <= m_out_d;
      done_q  <= done_d;
    end
  end

  assign m_out = m_out_q;
  assign done  = done_q;

endmodule

// File: tb/tb_matrix_transpose.sv
// tb/tb_matrix_transpose.sv - randomized and directed check of matrix_transpose
module tb_matrix_transpose;

  typedef int mat_t [4][4];

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [255:0] matrix;
  logic [255:0] m_out;
  logic         done;

  int total = 0;
  int bad   = 0;

  logic [255:0] exp_m = '0;
  logic         exp_d = 1'b0;

  matrix_transpose dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .matrix (matrix),
    .m_out  (m_out),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] mk(input mat_t a);
    logic [255:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v = v | (256'(a[r][c] & 32'hFFFF) << (16 * (4 * r + c)));
    return v;
  endfunction

  // Reference: unpack into a 2-D array, swap indices, repack
  function automatic logic [255:0] model_t(input logic [255:0] m);
    mat_t a;
    mat_t b;
    logic [255:0] tmp = m;
    for (int k = 0; k < 16; k++) begin
      a[k / 4][k % 4] = int'(tmp[15:0]);
      tmp = tmp >> 16;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = a[c][r];
    return mk(b);
  endfunction

  task automatic cyc(input string tag, input logic rst_n, input logic en, input logic [255:0] m);
    reset  = rst_n;
    enable = en;
    matrix = m;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_m = '0;
      exp_d = 1'b0;
    end else if (en) begin
      exp_m = model_t(m);
      exp_d = 1'b1;
    end else begin
      exp_d = 1'b0;
    end
    check({tag, ".m_out"}, m_out, exp_m);
    check({tag, ".done"}, {255'b0, done}, {255'b0, exp_d});
  endtask

  mat_t ref_rows = '{'{5, 8, 9, 2}, '{7, 3, 8, 4}, '{6, 5, 4, 3}, '{8, 5, 7, 6}};
  mat_t ref_tr   = '{'{5, 7, 6, 8}, '{8, 3, 5, 5}, '{9, 8, 4, 7}, '{2, 4, 3, 6}};
  mat_t ident, bnd, bnd_tr, sym;
  logic [255:0] ref_m, ref_exp, id_m, all_f, held;

  initial begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ident[r][c]  = (r == c) ? 1 : 0;
        bnd[r][c]    = 32'h8000 | (r << 4) | c;
        bnd_tr[r][c] = 32'h8000 | (c << 4) | r;
        sym[r][c]    = r + c;
      end
    ref_m   = mk(ref_rows);
    ref_exp = mk(ref_tr);
    id_m    = mk(ident);
    all_f   = {256{1'b1}};

    cyc("reset_state", 1'b0, 1'b0, '0);

    cyc("ref_capture", 1'b1, 1'b1, ref_m);
    check("ref_const", m_out, ref_exp);

    cyc("reset_prio", 1'b0, 1'b1, ref_m);
    check("reset_prio_zero", m_out, '0);
    cyc("reset_release", 1'b1, 1'b1, ref_m);
    check("release_const", m_out, ref_exp);

    held = m_out;
    for (int i = 0; i < 3; i++) begin
      cyc("hold", 1'b1, 1'b0, all_f);
      check("hold_const", m_out, held);
    end

    for (int i = 0; i < 6; i++) begin
      cyc("b2b", 1'b1, 1'b1, (i % 2 == 0) ? ref_m : id_m);
      check("b2b_const", m_out, (i % 2 == 0) ? ref_exp : id_m);
    end

    cyc("boundary", 1'b1, 1'b1, mk(bnd));
    check("boundary_const", m_out, mk(bnd_tr));
    check("corner_0_3", {240'b0, m_out[3*16 +: 16]}, {240'b0, 16'h8030});
    check("corner_3_0", {240'b0, m_out[12*16 +: 16]}, {240'b0, 16'h8003});

    cyc("symmetric", 1'b1, 1'b1, mk(sym));
    check("symmetric_const", m_out, mk(sym));

    for (int i = 0; i < 300; i++) begin
      logic [255:0] rm;
      for (int k = 0; k < 8; k++) rm[k*32 +: 32] = $urandom;
      cyc("random", ($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1, rm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
